// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC, one-word fetch buffer, valid/ready handoff to decode.
// Ports: clk, rst_n, start, halt_req, br_valid/br_target, imem_addr/imem_rdata,
//   if_valid/if_ready/if_pc/if_instr, busy; stall_cnt when FETCH_STALL_CNT_EN is defined.
module fetch_controller #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [15:0]       if_instr,
  output logic              busy
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STALL,
    FLUSH,
    HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [15:0]       instr_q, instr_d;
  logic              load;
  logic              started;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    load    = 1'b0;
    started = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        valid_d = 1'b0;
        if (start) begin
          pc_d    = RESET_PC;
          state_d = RUN;
          started = 1'b1;
        end
      end
      RUN, STALL, FLUSH: begin
        if (br_valid) begin
          pc_d    = br_target;
          valid_d = 1'b0;
          state_d = FLUSH;
        end else if (halt_req) begin
          // Finish the held word first, then stop without a new load.
          if (!valid_q || if_ready) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            state_d = STALL;
          end
        end else if (!valid_q || if_ready) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
      ifpc_d  = pc_q;
      instr_d = imem_rdata;
      valid_d = 1'b1;
      pc_d    = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ifpc_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = ifpc_q;
  assign if_instr  = instr_q;
  assign busy      = (state_q == RUN) ||
                     (state_q == STALL) ||
                     (state_q == FLUSH);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts every cycle that ends with the word still held.
  always_comb begin
    cnt_d = cnt_q;
    if (started) begin
      cnt_d = '0;
    end else if (state_d == STALL && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  logic unused_started;
  assign unused_started = started;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_fetch_controller;

  localparam int         AW  = 8;
  localparam logic [7:0] RPC = 8'h00;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [7:0]  if_pc;
  logic [15:0] if_instr;
  logic        busy;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [256];

  int vectors;
  int miscompares;

  // Behavioural model: is a program running, where is the PC,
  // which word (if any) is on offer to decode.
  bit          m_busy;
  bit          m_valid;
  logic [7:0]  m_pc;
  logic [7:0]  m_ifpc;
  logic [15:0] m_instr;
  int          m_cnt;

  fetch_controller #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt_req  (halt_req),
    .br_valid  (br_valid),
    .br_target (br_target),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .busy      (busy)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy  = 0;
    m_valid = 0;
    m_pc    = RPC;
    m_ifpc  = 8'h00;
    m_instr = 16'h0000;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_pc   = RPC;
        m_cnt  = 0;
      end
    end else if (br_valid) begin
      m_pc    = br_target;
      m_valid = 0;
    end else if (m_valid && !if_ready) begin
      if (m_cnt < 65535) m_cnt++;
    end else if (halt_req) begin
      m_valid = 0;
      m_busy  = 0;
    end else begin
      m_ifpc  = m_pc;
      m_instr = mem[m_pc];
      m_valid = 1;
      m_pc    = m_pc + 8'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start     = 0;
    halt_req  = 0;
    br_valid  = 0;
    br_target = 8'h00;
    if_ready  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic go();
    if_ready = 1;
    start    = 1;
    tick();
    start    = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    vectors++;
    if ({if_valid, busy, if_pc, if_instr, imem_addr} !== {1'b0, 1'b0, 8'h00, 16'h0000, RPC}) begin
      miscompares++;
      $display("FAIL reset_vals: got v=%b b=%b pc=%h i=%h a=%h", if_valid, busy, if_pc, if_instr, imem_addr);
    end
    rst_n    = 1;
    br_valid = 1;
    br_target = 8'h33;
    halt_req = 1;
    if_ready = 1;
    repeat (3) tick();
    vectors++;
    if ({if_valid, busy, imem_addr} !== {1'b0, 1'b0, RPC}) begin
      miscompares++;
      $display("FAIL reset_idle: got v=%b b=%b a=%h want 0 0 %h", if_valid, busy, imem_addr, RPC);
    end
    idle_inputs();
  endtask

  task automatic test_seq();
    do_reset();
    go();
    vectors++;
    if ({if_valid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL seq_start: got v=%b b=%b want v=0 b=1", if_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 8'(i), 16'h1000 + 16'(i)}) begin
        miscompares++;
        $display("FAIL seq_word%0d: got v=%b pc=%h i=%h want 1 %h %h", i, if_valid, if_pc, if_instr, 8'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    go();
    repeat (3) tick();
    if_ready = 0;
    repeat (3) tick();
    vectors++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h02, 16'h1002, 8'h03}) begin
      miscompares++;
      $display("FAIL stall_hold: got v=%b pc=%h i=%h a=%h want 1 02 1002 03", if_valid, if_pc, if_instr, imem_addr);
    end
`ifdef FETCH_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
    if_ready = 1;
    tick();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 8'h03, 16'h1003}) begin
      miscompares++;
      $display("FAIL stall_resume: got v=%b pc=%h i=%h want 1 03 1003", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    go();
    repeat (3) tick();
    br_valid  = 1;
    br_target = 8'h40;
    tick();
    br_valid = 0;
    vectors++;
    if ({if_valid, busy, imem_addr} !== {1'b0, 1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL br_flush: got v=%b b=%b a=%h want 0 1 40", if_valid, busy, imem_addr);
    end
    tick();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 8'h40, 16'h1040}) begin
      miscompares++;
      $display("FAIL br_target: got v=%b pc=%h i=%h want 1 40 1040", if_valid, if_pc, if_instr);
    end
    tick();
    vectors++;
    if ({if_valid, if_pc} !== {1'b1, 8'h41}) begin
      miscompares++;
      $display("FAIL br_next: got v=%b pc=%h want 1 41", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    go();
    br_valid  = 1;
    br_target = 8'hFE;
    tick();
    br_valid = 0;
    repeat (2) tick();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 8'hFF, 16'h10FF}) begin
      miscompares++;
      $display("FAIL wrap_ff: got v=%b pc=%h i=%h want 1 ff 10ff", if_valid, if_pc, if_instr);
    end
    tick();
    vectors++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h00, 16'h1000, 8'h01}) begin
      miscompares++;
      $display("FAIL wrap_00: got v=%b pc=%h i=%h a=%h want 1 00 1000 01", if_valid, if_pc, if_instr, imem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    go();
    repeat (6) tick();
    if_ready = 0;
    tick();
    halt_req = 1;
    repeat (2) tick();
    vectors++;
    if ({if_valid, busy, if_pc, if_instr} !== {1'b1, 1'b1, 8'h05, 16'h1005}) begin
      miscompares++;
      $display("FAIL halt_wait: got v=%b b=%b pc=%h i=%h want 1 1 05 1005", if_valid, busy, if_pc, if_instr);
    end
    if_ready = 1;
    tick();
    vectors++;
    if ({if_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL halt_enter: got v=%b b=%b want 0 0", if_valid, busy);
    end
    halt_req = 0;
    tick();
    vectors++;
    if ({if_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL halt_stay: got v=%b b=%b want 0 0", if_valid, busy);
    end
    go();
    tick();
    vectors++;
    if ({if_valid, busy, if_pc, if_instr} !== {1'b1, 1'b1, 8'h00, 16'h1000}) begin
      miscompares++;
      $display("FAIL halt_restart: got v=%b b=%b pc=%h i=%h want 1 1 00 1000", if_valid, busy, if_pc, if_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go();
    repeat (3) tick();
    if_ready = 0;
    tick();
    #3;
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if ({if_valid, busy, if_pc, if_instr, imem_addr} !== {1'b0, 1'b0, 8'h00, 16'h0000, RPC}) begin
      miscompares++;
      $display("FAIL async_rst: got v=%b b=%b pc=%h i=%h a=%h", if_valid, busy, if_pc, if_instr, imem_addr);
    end
    #2;
    rst_n    = 1;
    if_ready = 1;
    repeat (2) tick();
    vectors++;
    if ({if_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL async_idle: got v=%b b=%b want 0 0", if_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [33:0] exp_v;
    logic [33:0] obs_v;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 600; n++) begin
      start     = ($urandom_range(0, 99) < 8);
      halt_req  = ($urandom_range(0, 99) < 4);
      br_valid  = ($urandom_range(0, 99) < 6);
      br_target = 8'($urandom);
      if_ready  = ($urandom_range(0, 99) < 65);
      tick();
      exp_v = {m_valid, m_busy, m_pc, m_ifpc, m_instr};
      obs_v = {if_valid, busy, imem_addr, if_pc, if_instr};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rand_cyc%0d: got %h want %h", n, obs_v, exp_v);
      end
`ifdef FETCH_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== 16'(m_cnt)) begin
        miscompares++;
        $display("FAIL rand_cnt%0d: got %0d want %0d", n, stall_cnt, m_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    model_reset();
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_seq();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0: PC loaded on reset and on start.
REQ-002 SHALL have parameter ADDR_W, default 8: PC/address width; instruction width fixed at 16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: leave IDLE/HALT and begin fetching at RESET_PC.
REQ-006 SHALL have port halt_req, input, 1: stop fetching after the current output word is consumed.
REQ-007 SHALL have port br_valid, input, 1: branch redirect strobe from execute.
REQ-008 SHALL have port br_target, input, ADDR_W: redirect address.
REQ-009 SHALL have port imem_addr, output, ADDR_W: instruction memory address; equals PC, combinational.
REQ-010 SHALL have port imem_rdata, input, 16: instruction memory data; combinational read of imem_addr.
REQ-011 SHALL have port if_valid, output, 1: if_pc/if_instr hold a valid fetched word.
REQ-012 SHALL have port if_ready, input, 1: decode accepts the word this cycle.
REQ-013 SHALL have port if_pc, output, ADDR_W: address of the word in if_instr.
REQ-014 SHALL have port if_instr, output, 16: fetched instruction.
REQ-015 SHALL have port busy, output, 1: high in RUN, STALL or FLUSH.

Function
REQ-016 SHALL implement states IDLE, RUN, STALL, FLUSH, HALT, held in a registered state variable.
REQ-017 IDLE/HALT: no fetch, if_valid=0, PC holds; start -> PC<=RESET_PC, state RUN.
REQ-018 RUN, load condition (!if_valid || if_ready): if_pc<=PC, if_instr<=imem_rdata, if_valid<=1, PC<=PC+1 (1-cycle latency).
REQ-019 RUN, if_valid && !if_ready: outputs and PC hold, state STALL.
REQ-020 STALL: outputs stable while if_ready=0; on if_ready, perform the REQ-018 load and return to RUN.
REQ-021 Handshake: transfer occurs only when if_valid && if_ready; if_pc/if_instr SHALL not change while if_valid && !if_ready.
REQ-022 br_valid in RUN/STALL/FLUSH: PC<=br_target, if_valid<=0 (word discarded, even if if_ready), state FLUSH; ignored in IDLE/HALT.
REQ-023 FLUSH: lasts exactly one cycle with if_valid=0, then RUN fetches from br_target.
REQ-024 PC increments modulo 2^ADDR_W (8'hFF -> 8'h00); no fault raised.
REQ-025 Priority per cycle: br_valid > halt_req > fetch/stall.
REQ-026 halt_req in RUN/STALL: no new load; state HALT once if_valid=0 or the word transfers that cycle; if_valid=0 in HALT.
REQ-027 start while busy SHALL be ignored; start and halt_req together in IDLE -> RUN (halt_req seen next cycle).

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, PC=RESET_PC, if_valid=0, if_pc=0, if_instr=0, busy=0, regardless of clk.
REQ-029 Reset asserted mid-fetch or mid-stall SHALL discard the held word; no transfer may be reported after rst_n falls.
REQ-030 After rst_n rises, block stays IDLE until start.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN: when defined, adds output stall_cnt (16 bits) counting cycles in STALL, saturating at 16'hFFFF, cleared by reset and by start.
REQ-032 Without FETCH_STALL_CNT_EN, stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, start, if_ready=1, memory word at addr n = 16'h1000+n -> if_valid from cycle after start; if_pc 0,1,2,3 with if_instr 16'h1000..16'h1003 on consecutive cycles.
REQ-034 if_ready=0 for 3 cycles while if_pc=8'h02 -> if_pc/if_instr hold 8'h02/16'h1002; PC stays 8'h03; stall_cnt=3 (macro on).
REQ-035 br_valid with br_target=8'h40 while if_valid=1, if_ready=1 -> next cycle if_valid=0 (FLUSH), following cycle if_pc=8'h40; no word from old path delivered.
REQ-036 PC=8'hFF in RUN, if_ready=1 -> if_pc 8'hFF then 8'h00.
REQ-037 halt_req while stalled at if_pc=8'h05 -> stays STALL until if_ready, word 8'h05 transfers, then HALT, busy=0, if_valid=0; start -> refetch from 8'h00.
REQ-038 rst_n pulsed low mid-stall between clock edges -> if_valid=0, busy=0 immediately; IDLE after release.
